mips_encode: RTL and testbench
==============================

# mips_encode

Inverse of the arithmetic instruction decoder. It accepts an ALU operation request (alu_op, immediate select, register fields, immediate) over a valid/ready handshake and assembles the 32-bit MIPS instruction word. Encoded words are buffered in a small FIFO and streamed out over a second valid/ready handshake. The block feeds instruction memory loaders and decoder self-test benches; requests with no legal encoding are flagged and dropped.

## Interface
- DEPTH, 4: FIFO entries, power of two, at least 2.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request this cycle.
- in_alu_op  input  3  operation code: ADD=2, SUB=3, AND=4, OR=5, NOR=6, XOR=7.
- in_imm_sel  input  1  1 selects I-type (immediate) form, 0 selects R-type.
- in_rs, in_rt, in_rd  input  5 each  register fields; in_rd is ignored for I-type.
- in_imm  input  16  immediate, inserted verbatim.
- out_valid  output  1  out_inst holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_inst  output  32  encoded instruction.
- except  output  1  one-cycle pulse after an unencodable request is accepted.
- err_count  output  8  count of unencodable requests, saturates at 255.
- inst_count  output  16  count of words delivered, wraps at 65535 to 0.

## Operation
- Accept: in_valid and in_ready. Deliver: out_valid and out_ready.
- R-type word is {6'h00, rs, rt, rd, 5'b0, funct}. funct values: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
- I-type word is {opcode, rs, rt, imm}. opcode values: ADDI 0x08, ANDI 0x0c, ORI 0x0d, XORI 0x0e.
- Unencodable requests:
  - alu_op 0 or 1, in either form;
  - SUB or NOR with in_imm_sel set.
- An unencodable request is still consumed (handshake completes) but is not written to the FIFO. except pulses and err_count increments.
- FIFO occupancy states:
  - EMPTY (count 0): out_valid=0, out_inst=0.
  - PARTIAL: both handshakes may proceed.
  - FULL (count DEPTH): in_ready=0.
- in_ready = (count != DEPTH), combinational from registered count only. A pop in the same cycle does not make room while FULL.
- Simultaneous push and pop in PARTIAL leaves count unchanged and preserves order.
- A pop when EMPTY cannot occur (out_valid=0).
- out_inst is the FIFO head and stays stable while out_valid=1 and out_ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Reset values: out_valid=0, out_inst=0, except=0, err_count=0, inst_count=0, in_ready=1, FIFO empty.
- Reset asserted mid-operation clears everything asynchronously and discards buffered words.
- Latency: a word accepted in cycle N is visible on out_inst/out_valid in cycle N+1 if the FIFO was empty. There is no combinational path from input to output.
- except is registered: request accepted in cycle N gives except=1 in cycle N+1 only.
- err_count and inst_count update on the edge following their event.
- Sustained throughput is one word per cycle in PARTIAL.

## Structure
- Shared package mips_defs holds the ALU_* op codes, OP0_* funct codes and OP_* immediate opcodes. The existing decoder uses the same package so encode and decode cannot diverge.
- Sub-module mips_inst_fifo: a synchronous FIFO, DEPTH entries by 32 bits, with push, pop, count, head and the same clock/reset.
- Top-level mips_encode holds:
  - combinational encode and legality logic;
  - the except register;
  - both counters.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 -> next cycle out_valid=1, out_inst=0x00221820; after delivery inst_count=1.
- ADDI rs=4 rt=5 imm=0xFFFF -> out_inst=0x2085FFFF.
- XORI rs=0 rt=31 imm=0x1234 -> out_inst=0x381F1234.
- SUB with in_imm_sel=1 -> single except pulse, err_count=1, out_valid stays 0, in_ready stays 1. alu_op=0 gives the same response; 300 bad requests -> err_count=255.
- Backpressure: hold out_ready=0 and push 5 requests.
  - in_ready drops after the 4th; the 5th waits.
  - Raising out_ready drains 4 words in order, then the 5th; inst_count=5.
- With count=2, push and pop in the same cycle -> count stays 2, order intact.
- Assert reset mid-drain -> out_valid=0 and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_defs.sv
// Opcode, funct and ALU-op constants shared by the MIPS encoder and decoder,
// plus the single encode function that turns an ALU request into a word.
package mips_defs;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_XOR = 6'h26;
  localparam logic [5:0] OP0_NOR = 6'h27;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_result_t;

  // SUB and NOR have no immediate form in the base ISA, so they are illegal as I-type.
  function automatic enc_result_t encode_alu(
    input logic [2:0]  op,
    input logic        imm_sel,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    enc_result_t r;
    logic [5:0]  code;
    logic        legal;
    code  = 6'h00;
    legal = 1'b1;
    if (imm_sel) begin
      case (op)
        ALU_ADD: code = OP_ADDI;
        ALU_AND: code = OP_ANDI;
        ALU_OR:  code = OP_ORI;
        ALU_XOR: code = OP_XORI;
        default: legal = 1'b0;
      endcase
      r.word = {code, rs, rt, imm};
    end else begin
      case (op)
        ALU_ADD: code = OP0_ADD;
        ALU_SUB: code = OP0_SUB;
        ALU_AND: code = OP0_AND;
        ALU_OR:  code = OP0_OR;
        ALU_NOR: code = OP0_NOR;
        ALU_XOR: code = OP0_XOR;
        default: legal = 1'b0;
      endcase
      r.word = {OP_RTYPE, rs, rt, rd, 5'b00000, code};
    end
    r.legal = legal;
    if (!legal) begin
      r.word = 32'h0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_inst_fifo.sv
// Instruction-word FIFO: DEPTH x 32, occupancy tracked as EMPTY/PARTIAL/FULL.
// The head reads as zero while empty so downstream never sees stale words.
module mips_inst_fifo
  import mips_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] data_i,
  output logic [31:0] head_o,
  output logic [AW:0] count_o,
  output logic        valid_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  fifo_state_e   state_q, state_d;
  logic          do_push, do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push_i & (count_q != FULL_CNT);
  assign do_pop  = pop_i & (state_q != FIFO_EMPTY);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (count_d == '0) begin
      state_d = FIFO_EMPTY;
    end else if (count_d == FULL_CNT) begin
      state_d = FIFO_FULL;
    end else begin
      state_d = FIFO_PARTIAL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= FIFO_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = (state_q == FIFO_EMPTY) ? 32'h0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = (state_q != FIFO_EMPTY);

endmodule

// File: rtl/mips_encode.sv
// ALU request -> 32-bit MIPS word encoder with output FIFO, error pulse,
// saturating error counter and wrapping delivered-word counter.
module mips_encode
  import mips_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  in_alu_op_i,
  input  logic        in_imm_sel_i,
  input  logic [4:0]  in_rs_i,
  input  logic [4:0]  in_rt_i,
  input  logic [4:0]  in_rd_i,
  input  logic [15:0] in_imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic        except_o,
  output logic [7:0]  err_count_o,
  output logic [15:0] inst_count_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  enc_result_t enc;
  logic        accept, push, bad, deliver;
  logic [AW:0] fifo_count;
  logic        except_q, except_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] inst_q, inst_d;

  assign enc = encode_alu(in_alu_op_i, in_imm_sel_i, in_rs_i, in_rt_i, in_rd_i, in_imm_i);

  // Ready depends on registered occupancy only, never on out_ready.
  assign in_ready_o = (fifo_count != FULL_CNT);
  assign accept     = in_valid_i & in_ready_o;
  assign push       = accept & enc.legal;
  assign bad        = accept & ~enc.legal;
  assign deliver    = out_valid_o & out_ready_i;

  mips_inst_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (deliver),
    .data_i  (enc.word),
    .head_o  (out_inst_o),
    .count_o (fifo_count),
    .valid_o (out_valid_o)
  );

  always_comb begin
    except_d = bad;
    err_d    = err_q;
    inst_d   = inst_q;
    if (bad && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
    if (deliver) begin
      inst_d = inst_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      except_q <= 1'b0;
      err_q    <= 8'h00;
      inst_q   <= 16'h0000;
    end else begin
      except_q <= except_d;
      err_q    <= err_d;
      inst_q   <= inst_d;
    end
  end

  assign except_o     = except_q;
  assign err_count_o  = err_q;
  assign inst_count_o = inst_q;

endmodule

// File: tb/tb_mips_encode.sv
// Directed bench for mips_encode: encoding table, error handling, backpressure,
// simultaneous push/pop and asynchronous reset during drain.
module tb_mips_encode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_alu_op = 3'd0;
  logic        in_imm_sel = 1'b0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [15:0] in_imm = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        except_w;
  logic [7:0]  err_count;
  logic [15:0] inst_count;

  int n_pass = 0;
  int n_total = 0;
  int exp_inst = 0;
  int exp_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mips_encode #(.DEPTH(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_alu_op_i  (in_alu_op),
    .in_imm_sel_i (in_imm_sel),
    .in_rs_i      (in_rs),
    .in_rt_i      (in_rt),
    .in_rd_i      (in_rd),
    .in_imm_i     (in_imm),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_inst_o   (out_inst),
    .except_o     (except_w),
    .err_count_o  (err_count),
    .inst_count_o (inst_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic        sel;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] addw(input logic [4:0] k);
    return {6'h00, k, k, k, 5'b00000, 6'h20};
  endfunction

  // One cycle of streaming ADD traffic checked against a queue model.
  task automatic step(input logic v, input int k, input logic rdy, output logic acc);
    logic had_room;
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
    chk("head", out_inst, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() != 4});
    chk("inst_count", {16'b0, inst_count}, 32'(exp_inst));
    in_valid = v; in_alu_op = 3'd2; in_imm_sel = 1'b0;
    in_rs = 5'(k); in_rt = 5'(k); in_rd = 5'(k); in_imm = 16'h0;
    out_ready = rdy;
    had_room = (exp_q.size() != 4);
    if (rdy && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_inst++;
    end
    acc = v && had_room;
    if (acc) exp_q.push_back(addw(5'(k)));
    $display("step v=%0d k=%0d rdy=%0d acc=%0d depth=%0d", v, k, rdy, acc, exp_q.size());
  endtask

  initial begin
    logic acc;
    int   k;

    vecs[0]  = '{3'd2, 1'b0, 5'd1,  5'd2,  5'd3,  16'hABCD, 1'b1, 32'h00221820};
    vecs[1]  = '{3'd2, 1'b1, 5'd4,  5'd5,  5'd31, 16'hFFFF, 1'b1, 32'h2085FFFF};
    vecs[2]  = '{3'd7, 1'b1, 5'd0,  5'd31, 5'd0,  16'h1234, 1'b1, 32'h381F1234};
    vecs[3]  = '{3'd3, 1'b0, 5'd1,  5'd2,  5'd3,  16'h0000, 1'b1, 32'h00221822};
    vecs[4]  = '{3'd4, 1'b0, 5'd31, 5'd31, 5'd31, 16'h0000, 1'b1, 32'h03FFF824};
    vecs[5]  = '{3'd5, 1'b0, 5'd5,  5'd6,  5'd7,  16'h0000, 1'b1, 32'h00A63825};
    vecs[6]  = '{3'd7, 1'b0, 5'd0,  5'd0,  5'd1,  16'h0000, 1'b1, 32'h00000826};
    vecs[7]  = '{3'd6, 1'b0, 5'd2,  5'd3,  5'd4,  16'h0000, 1'b1, 32'h00432027};
    vecs[8]  = '{3'd4, 1'b1, 5'd1,  5'd2,  5'd0,  16'h00FF, 1'b1, 32'h302200FF};
    vecs[9]  = '{3'd5, 1'b1, 5'd3,  5'd4,  5'd0,  16'h8000, 1'b1, 32'h34648000};
    vecs[10] = '{3'd3, 1'b1, 5'd1,  5'd2,  5'd3,  16'h0001, 1'b0, 32'h00000000};
    vecs[11] = '{3'd6, 1'b1, 5'd1,  5'd2,  5'd3,  16'h0001, 1'b0, 32'h00000000};
    vecs[12] = '{3'd0, 1'b0, 5'd1,  5'd2,  5'd3,  16'h0000, 1'b0, 32'h00000000};
    vecs[13] = '{3'd1, 1'b1, 5'd1,  5'd2,  5'd3,  16'h0000, 1'b0, 32'h00000000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_except", {31'b0, except_w}, 32'd0);
    chk("rst_err", {24'b0, err_count}, 32'd0);
    chk("rst_inst", {16'b0, inst_count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Encoding table: one request, then observe result and drain
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_alu_op = vecs[i].op; in_imm_sel = vecs[i].sel;
      in_rs = vecs[i].rs; in_rt = vecs[i].rt; in_rd = vecs[i].rd; in_imm = vecs[i].imm;
      out_ready = 1'b1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (vecs[i].legal) begin
        chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
        chk($sformatf("v%0d_out_inst", i), out_inst, vecs[i].word);
        chk($sformatf("v%0d_except", i), {31'b0, except_w}, 32'd0);
        exp_inst++;
      end else begin
        exp_err++;
        chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'd0);
        chk($sformatf("v%0d_except", i), {31'b0, except_w}, 32'd1);
        chk($sformatf("v%0d_err", i), {24'b0, err_count}, 32'(exp_err));
      end
      @(negedge clk);
      chk($sformatf("v%0d_after_valid", i), {31'b0, out_valid}, 32'd0);
      chk($sformatf("v%0d_after_except", i), {31'b0, except_w}, 32'd0);
      chk($sformatf("v%0d_inst_count", i), {16'b0, inst_count}, 32'(exp_inst));
      $display("vec %0d op=%0d sel=%0d word=%08h except=%0d err=%0d", i, vecs[i].op,
               vecs[i].sel, vecs[i].word, !vecs[i].legal, err_count);
    end

    // 300 unencodable requests saturate err_count
    @(negedge clk);
    in_valid = 1'b1; in_alu_op = 3'd0; in_imm_sel = 1'b0; out_ready = 1'b1;
    repeat (300) @(negedge clk);
    chk("sat_err", {24'b0, err_count}, 32'd255);
    chk("sat_except", {31'b0, except_w}, 32'd1);
    chk("sat_out_valid", {31'b0, out_valid}, 32'd0);
    chk("sat_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_except_drop", {31'b0, except_w}, 32'd0);
    chk("sat_err_hold", {24'b0, err_count}, 32'd255);
    $display("saturation err_count=%0d", err_count);

    // Backpressure: 5 requests with out_ready low, then drain
    k = 1;
    repeat (6) begin
      step(1'b1, k, 1'b0, acc);
      if (acc) k++;
    end
    for (int i = 0; i < 20 && (exp_q.size() != 0 || k <= 5); i++) begin
      step(k <= 5, k, 1'b1, acc);
      if (acc) k++;
    end
    step(1'b0, 0, 1'b0, acc);

    // Push and pop together at count 2, then fill and drain
    step(1'b1, 10, 1'b0, acc);
    step(1'b1, 11, 1'b0, acc);
    step(1'b1, 12, 1'b1, acc);
    step(1'b1, 13, 1'b0, acc);
    step(1'b1, 14, 1'b0, acc);
    step(1'b1, 15, 1'b0, acc);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1, acc);
    step(1'b0, 0, 1'b0, acc);

    // Asynchronous reset in the middle of a drain
    step(1'b1, 20, 1'b0, acc);
    step(1'b1, 21, 1'b0, acc);
    step(1'b1, 22, 1'b0, acc);
    step(1'b0, 0, 1'b1, acc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_out_inst", out_inst, 32'h0);
    chk("async_inst", {16'b0, inst_count}, 32'd0);
    chk("async_err", {24'b0, err_count}, 32'd0);
    chk("async_in_ready", {31'b0, in_ready}, 32'd1);
    $display("async reset out_valid=%0d inst_count=%0d", out_valid, inst_count);
    in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    exp_inst = 0;
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 7, 1'b1, acc);
    step(1'b0, 0, 1'b1, acc);
    step(1'b0, 0, 1'b0, acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
